fifo_fwft: RTL and testbench



---
 rtl/fifo_fwft.sv | 151 +++++++++++++++
 tb/tb_fifo_fwft.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fifo_fwft.sv
// fifo_fwft: first-word-fall-through FIFO. The RAM is a block RAM with a
// 1-cycle synchronous read. A two-entry output stage (OREG, then PREG) hides
// that latency, so the head word is always presented on out_data.
// Total capacity is DEPTH + 2 entries.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset (rst wins over flush)
//   flush               synchronous clear of all contents
//   in_data/in_valid    producer side; a push happens when in_valid && in_ready
//   in_ready
//   out_data/out_valid  consumer side; a pop happens when out_valid && out_ready
//   out_ready
//   count               occupancy (RAM + read in flight + output stage)
//   almost_full         count >= AFULL_THRESH
//   almost_empty        count <= AEMPTY_THRESH
//
// Output-stage states:
//   state    | meaning
//   ST_EMPTY | OREG and PREG both empty
//   ST_ONE   | OREG valid, PREG empty
//   ST_TWO   | OREG and PREG both valid
module fifo_fwft #(
  parameter int DWIDTH        = 16,
  parameter int ADDR_WIDTH    = 7,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DWIDTH-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DWIDTH-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CAP   = DEPTH + 2;
  localparam logic [ADDR_WIDTH:0] CAP_C    = CAP[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE_C    = 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} stage_t;

  stage_t state, state_next;

  logic [DWIDTH-1:0]   mem [DEPTH];
  logic [DWIDTH-1:0]   ram_q;
  logic [DWIDTH-1:0]   oreg, preg, oreg_next, preg_next, arr0;
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic                rd_vld;
  logic                push, pop, ram_empty, push_stage, ram_we, ram_re;
  logic [1:0]          occ, held, arrivals, occ_next;

  assign ram_empty    = (wr_ptr == rd_ptr);
  assign in_ready     = ~rst & ~flush & (count < CAP_C);
  assign out_valid    = (state != ST_EMPTY);
  assign out_data     = oreg;
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);
  assign push         = in_valid & in_ready;
  assign pop          = out_valid & out_ready & ~rst & ~flush;

  // Words enter the output stage in FIFO order: first the returning RAM read
  // (which is older), then a bypassed push. A push may only bypass the RAM
  // when the RAM holds nothing and the stage still has room after the read
  // return. As a result, whenever the RAM is non-empty, either PREG is full
  // or a read is in flight. That keeps the RAM from ever overfilling.
  always_comb begin
    state_next = state;
    oreg_next  = oreg;
    preg_next  = preg;
    occ        = 2'd0;
    push_stage = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    arr0       = rd_vld ? ram_q : in_data;

    case (state)
      ST_ONE:  occ = 2'd1;
      ST_TWO:  occ = 2'd2;
      default: occ = 2'd0;
    endcase

    held       = occ - {1'b0, pop};
    push_stage = push & ram_empty & ((held + {1'b0, rd_vld}) < 2'd2);
    ram_we     = push & ~push_stage;
    arrivals   = {1'b0, rd_vld} + {1'b0, push_stage};
    occ_next   = held + arrivals;

    // Issue a read only if the returning word is sure to find a free slot
    // next cycle, even when nothing is popped then.
    ram_re = ~rst & ~flush & ~ram_empty & (occ_next < 2'd2);

    if (pop && state == ST_TWO) oreg_next = preg;
    case (held)
      2'd0: begin
        if (arrivals != 2'd0) oreg_next = arr0;
        if (arrivals == 2'd2) preg_next = in_data;
      end
      2'd1: begin
        if (arrivals != 2'd0) preg_next = arr0;
      end
      default: ;
    endcase

    case (occ_next)
      2'd0:    state_next = ST_EMPTY;
      2'd1:    state_next = ST_ONE;
      default: state_next = ST_TWO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state  <= ST_EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_vld <= 1'b0;
      count  <= '0;
    end else begin
      state  <= state_next;
      rd_vld <= ram_re;
      if (ram_we) wr_ptr <= wr_ptr + ONE_C;
      if (ram_re) rd_ptr <= rd_ptr + ONE_C;
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

  // Output-stage data needs no reset; state alone qualifies it.
  always_ff @(posedge clk) begin
    oreg <= oreg_next;
    preg <= preg_next;
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_ptr[ADDR_WIDTH-1:0]] <= in_data;
    if (ram_re) ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

endmodule

// File: tb/tb_fifo_fwft.sv
// tb_fifo_fwft: directed plus randomized stimulus for fifo_fwft, checked
// every cycle against a queue model of the FIFO contents.
module tb_fifo_fwft;
  localparam int DW  = 16;
  localparam int AW  = 7;
  localparam int CAP = (2**AW) + 2;
  localparam int AF  = (2**AW) - 4;
  localparam int AE  = 2;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic          in_ready, out_valid, almost_full, almost_empty;
  logic [AW:0]   count;

  int            checks = 0;
  int            errors = 0;
  int            pushes = 0;
  bit            primed = 1'b0;
  logic [DW-1:0] q[$];

  always #5 clk = ~clk;

  fifo_fwft #(
    .DWIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, checks outputs against the model mid-cycle,
  // then applies the cycle's push/pop to the model at the rising edge.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                      input logic fl, input logic rs);
    bit push_m, pop_m;
    int n;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    #1;
    n = q.size();
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!rs && !fl && n < CAP)});
    if (primed) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, (n > 0)});
      chk("count", {24'd0, count}, n);
      chk("almost_full", {31'd0, almost_full}, {31'd0, (n >= AF)});
      chk("almost_empty", {31'd0, almost_empty}, {31'd0, (n <= AE)});
      if (n > 0) chk("out_data", {16'd0, out_data}, {16'd0, q[0]});
    end
    push_m = iv && !rs && !fl && (n < CAP);
    pop_m  = ordy && !rs && !fl && (n > 0);
    @(posedge clk);
    if (rs || fl) begin
      q.delete();
    end else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
        q.push_back(d);
        pushes++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    primed = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // fill to capacity, then try to push more
    for (int i = 0; i < CAP; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    // full: push and pop on the same edge -> only the pop happens
    step(1'b1, 16'hEEEE, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    // drain, including pops requested while empty
    for (int i = 0; i < CAP + 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // empty bypass
    step(1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // randomized streaming
    pushes = 0;
    for (int c = 0; c < 6000 && pushes < 1000; c++)
      step($urandom_range(0, 9) < 8, 16'($urandom), $urandom_range(0, 9) < 7, 1'b0, 1'b0);
    chk("stream_words", {31'd0, (pushes >= 1000)}, 32'd1);
    for (int i = 0; i < CAP + 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // flush with a RAM read in flight
    for (int i = 0; i < 51; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h5555, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // reset mid-stream at count 77
    for (int i = 0; i < 77; i++) step(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h7777, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h4321, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
